shift_unit_iter: RTL and testbench

//  Multi-cycle shifter in EX for SLL/SRL/SRA/SLLV/SRLV/SRAV.

---
 rtl/shift_unit_iter.sv | 123 ++++++++++++
 tb/tb_shift_unit_iter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_iter.sv
// Iterative EX-stage shifter: shifts the rt operand by up to STEP bits per cycle,
// holding busy while shifting and pulsing done for one cycle when the result is final.
module shift_unit_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] shamt_ext,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] STEP_AMT = SW'(STEP);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  logic [1:0]       state_r, state_s;
  logic [WIDTH-1:0] work_r, work_s;
  logic [SW-1:0]    rem_r, rem_s;
  logic [SW-1:0]    step_s;
  logic [1:0]       op_r, op_s;
  logic             sign_r, sign_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             accept_s;
  logic             unused_s;

  // One partial shift; SRA fills the vacated top bits with the sign latched at accept.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] w,
    input logic [1:0]       o,
    input logic             sgn,
    input logic [SW-1:0]    s
  );
    logic [WIDTH-1:0] fill;
    fill = sgn ? ~({WIDTH{1'b1}} >> s) : {WIDTH{1'b0}};
    case (o)
      OP_SLL:  shift_step = w << s;
      OP_SRL:  shift_step = w >> s;
      OP_SRA:  shift_step = (w >> s) | fill;
      default: shift_step = w;
    endcase
  endfunction

  assign unused_s = ^shamt_ext[WIDTH-1:SW];

  // Next-state, work-register and output-flag computation.
  always_comb begin
    state_s  = state_r;
    work_s   = work_r;
    rem_s    = rem_r;
    op_s     = op_r;
    sign_s   = sign_r;
    step_s   = (rem_r < STEP_AMT) ? rem_r : STEP_AMT;
    accept_s = start && !flush && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    if (flush) begin
      state_s = ST_IDLE;
    end else if (accept_s) begin
      op_s   = op;
      work_s = a;
      rem_s  = shamt_ext[SW-1:0];
      sign_s = a[WIDTH-1];
      if ((shamt_ext[SW-1:0] == {SW{1'b0}}) || (op == OP_PASS)) begin
        state_s = ST_DONE;
      end else begin
        state_s = ST_SHIFT;
      end
    end else begin
      case (state_r)
        ST_IDLE: state_s = ST_IDLE;
        ST_SHIFT: begin
          work_s  = shift_step(work_r, op_r, sign_r, step_s);
          rem_s   = rem_r - step_s;
          state_s = (rem_s == {SW{1'b0}}) ? ST_DONE : ST_SHIFT;
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
    busy_s = (state_s == ST_SHIFT);
    done_s = (state_s == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      work_r  <= {WIDTH{1'b0}};
      rem_r   <= {SW{1'b0}};
      op_r    <= 2'b00;
      sign_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      work_r  <= work_s;
      rem_r   <= rem_s;
      op_r    <= op_s;
      sign_r  <= sign_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = work_r;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed bench for shift_unit_iter: one instance with STEP=1 and one with STEP=4
// share the same stimulus; each task checks its own expectations inline.
module tb_shift_unit_iter;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, shamt_ext;
  logic        busy1, done1, busy4, done4;
  logic [31:0] result1, result4;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] sh;
    logic [31:0] res;
    int          dc1;
    int          dc4;
  } vec_t;

  always #5 clk = ~clk;

  shift_unit_iter #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .shamt_ext(shamt_ext),
    .flush(flush), .busy(busy1), .done(done1), .result(result1)
  );

  shift_unit_iter #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .shamt_ext(shamt_ext),
    .flush(flush), .busy(busy4), .done(done4), .result(result4)
  );

  // Issue one operation and observe both instances over a fixed 40-cycle window.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] sh,
                        output int dc1, output int dc4, output int bc1, output int bc4,
                        output int pc1, output int pc4);
    dc1 = 0; dc4 = 0; bc1 = 0; bc4 = 0; pc1 = 0; pc4 = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = av; shamt_ext = sh;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy1) bc1++;
      if (busy4) bc4++;
      if (done1) begin pc1++; if (dc1 == 0) dc1 = c; end
      if (done4) begin pc4++; if (dc4 == 0) dc4 = c; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = 32'h0; shamt_ext = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || result1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_s1 busy=%b done=%b result=%h want 0 0 00000000", busy1, done1, result1);
    end
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || result4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_s4 busy=%b done=%b result=%h want 0 0 00000000", busy4, done4, result4);
    end
    rst = 1'b0;
  endtask

  task automatic check_vectors(input vec_t tbl[$], input string tag);
    int dc1, dc4, bc1, bc4, pc1, pc4;
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].sh, dc1, dc4, bc1, bc4, pc1, pc4);
      checks++;
      if (dc1 !== tbl[i].dc1) begin errors++; $display("FAIL %s_lat1 vec %0d got %0d want %0d", tag, i, dc1, tbl[i].dc1); end
      checks++;
      if (dc4 !== tbl[i].dc4) begin errors++; $display("FAIL %s_lat4 vec %0d got %0d want %0d", tag, i, dc4, tbl[i].dc4); end
      checks++;
      if (bc1 !== tbl[i].dc1 - 1 || bc4 !== tbl[i].dc4 - 1) begin
        errors++; $display("FAIL %s_busy vec %0d got %0d/%0d want %0d/%0d", tag, i, bc1, bc4, tbl[i].dc1 - 1, tbl[i].dc4 - 1);
      end
      checks++;
      if (pc1 !== 1 || pc4 !== 1) begin errors++; $display("FAIL %s_pulses vec %0d got %0d/%0d want 1/1", tag, i, pc1, pc4); end
      checks++;
      if (result1 !== tbl[i].res) begin errors++; $display("FAIL %s_res1 vec %0d got %h want %h", tag, i, result1, tbl[i].res); end
      checks++;
      if (result4 !== tbl[i].res) begin errors++; $display("FAIL %s_res4 vec %0d got %h want %h", tag, i, result4, tbl[i].res); end
    end
  endtask

  task automatic test_shifts();
    vec_t tbl[$];
    tbl.push_back('{2'b00, 32'h00000001, 32'd31,        32'h80000000, 32, 9});
    tbl.push_back('{2'b10, 32'h80000000, 32'd4,         32'hF8000000, 5,  2});
    tbl.push_back('{2'b01, 32'hDEADBEEF, 32'h00000025,  32'h06F56DF7, 6,  3});
    tbl.push_back('{2'b10, 32'h80000000, 32'd31,        32'hFFFFFFFF, 32, 9});
    tbl.push_back('{2'b10, 32'h7FFFFFFF, 32'd31,        32'h00000000, 32, 9});
    tbl.push_back('{2'b00, 32'h0000F00F, 32'd8,         32'h00F00F00, 9,  3});
    tbl.push_back('{2'b01, 32'h80000000, 32'hFFFFFFE3,  32'h10000000, 4,  2});
    tbl.push_back('{2'b10, 32'hF0000000, 32'h00000021,  32'hF8000000, 2,  2});
    check_vectors(tbl, "shift");
  endtask

  task automatic test_zero_and_pass();
    vec_t tbl[$];
    tbl.push_back('{2'b00, 32'h12345678, 32'd0,        32'h12345678, 1, 1});
    tbl.push_back('{2'b11, 32'h12345678, 32'd9,        32'h12345678, 1, 1});
    tbl.push_back('{2'b10, 32'h87654321, 32'h00000020, 32'h87654321, 1, 1});
    check_vectors(tbl, "zero_pass");
  endtask

  task automatic test_flush();
    int pc1 = 0;
    int pc4 = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h1; shamt_ext = 32'd20;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done1) pc1++;
      if (done4) pc4++;
      if (c == 2) begin
        checks++;
        if (busy1 !== 1'b1 || busy4 !== 1'b1) begin errors++; $display("FAIL flush_busy_pre got %b/%b want 1/1", busy1, busy4); end
      end
      if (c == 6) begin
        checks++;
        if (busy1 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL flush_busy_post got %b/%b want 0/0", busy1, busy4); end
        checks++;
        if (result1 !== 32'h00000010) begin errors++; $display("FAIL flush_res1 got %h want 00000010", result1); end
        checks++;
        if (result4 !== 32'h00010000) begin errors++; $display("FAIL flush_res4 got %h want 00010000", result4); end
      end
      start = (c == 3);
      flush = (c == 5);
      if (c == 3) begin op = 2'b11; a = 32'hFFFFFFFF; shamt_ext = 32'h0; end
    end
    checks++;
    if (pc1 !== 0 || pc4 !== 0) begin errors++; $display("FAIL flush_no_done got %0d/%0d pulses want 0/0", pc1, pc4); end
    checks++;
    if (result1 !== 32'h00000010) begin errors++; $display("FAIL flush_hold got %h want 00000010", result1); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h3; shamt_ext = 32'd2;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (done1 !== ((c == 3) || (c == 7))) begin errors++; $display("FAIL b2b_done1 cycle %0d got %b want %b", c, done1, (c == 3) || (c == 7)); end
      checks++;
      if (done4 !== ((c == 2) || (c == 5))) begin errors++; $display("FAIL b2b_done4 cycle %0d got %b want %b", c, done4, (c == 2) || (c == 5)); end
      if (c == 3) begin
        checks++;
        if (result1 !== 32'h0000000C) begin errors++; $display("FAIL b2b_first_res got %h want 0000000C", result1); end
      end
      if (c == 4) begin
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL b2b_no_gap got %b want 1", busy1); end
      end
      if (c == 7) begin
        checks++;
        if (result1 !== 32'h00000010) begin errors++; $display("FAIL b2b_second_res1 got %h want 00000010", result1); end
      end
      if (c == 5) begin
        checks++;
        if (result4 !== 32'h00000010) begin errors++; $display("FAIL b2b_second_res4 got %h want 00000010", result4); end
      end
      start = (c == 3);
      if (c == 3) begin op = 2'b01; a = 32'h80; shamt_ext = 32'd3; end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h1; shamt_ext = 32'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got %b want 1", busy1); end
    rst = 1'b1; start = 1'b1; op = 2'b11; a = 32'hA5A5A5A5;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || result1 !== 32'h0) begin
      errors++; $display("FAIL rstmid_s1 busy=%b done=%b result=%h want 0 0 00000000", busy1, done1, result1);
    end
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || result4 !== 32'h0) begin
      errors++; $display("FAIL rstmid_s4 busy=%b done=%b result=%h want 0 0 00000000", busy4, done4, result4);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL rstmid_idle got busy=%b done=%b want 0 0", busy1, done1); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = 32'h0; shamt_ext = 32'h0;
    test_reset();
    test_shifts();
    test_zero_and_pass();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
